// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: moves a player token through the wall map produced by
// maze_generator. Handles button priority, hold-to-repeat, wall/bound checks,
// move counting and goal detection. All outputs are registered.
module maze_player_ctrl #(
  parameter int COLS          = 10,
  parameter int ROWS          = 15,
  parameter int GOAL_X        = 9,
  parameter int GOAL_Y        = 14,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         maze_ready,
  input  logic [COLS*(ROWS+1)-1:0]     h_walls,
  input  logic [ROWS*(COLS+1)-1:0]     v_walls,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_left,
  input  logic                         btn_right,
  output logic [3:0]                   pos_x,
  output logic [3:0]                   pos_y,
  output logic [15:0]                  moves,
  output logic                         bump,
  output logic                         win
);

  localparam int HW_W = COLS * (ROWS + 1);
  localparam int VW_W = ROWS * (COLS + 1);
  localparam int HI_W = $clog2(HW_W);
  localparam int VI_W = $clog2(VW_W);
  // hold_cnt never exceeds REPEAT_DELAY-1, so clog2(REPEAT_DELAY) bits suffice
  localparam int HC_W = $clog2(REPEAT_DELAY);

  localparam logic [HC_W-1:0] LP_HOLD_LAST   = HC_W'(REPEAT_DELAY - 1);
  localparam logic [HC_W-1:0] LP_HOLD_RELOAD = HC_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [3:0]      LP_LAST_X      = 4'(COLS - 1);
  localparam logic [3:0]      LP_LAST_Y      = 4'(ROWS - 1);
  localparam logic [3:0]      LP_GOAL_X      = 4'(GOAL_X);
  localparam logic [3:0]      LP_GOAL_Y      = 4'(GOAL_Y);

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

  state_t            r_state;
  dir_t              r_prev_dir;
  logic [HC_W-1:0]   r_hold_cnt;
  logic [3:0]        r_pos_x;
  logic [3:0]        r_pos_y;
  logic [15:0]       r_moves;
  logic              r_bump;
  logic              r_win;

  dir_t              w_dir;
  logic              w_req;
  logic [HC_W-1:0]   w_hold_nxt;
  logic [HI_W-1:0]   w_h_idx_up;
  logic [HI_W-1:0]   w_h_idx_down;
  logic [VI_W-1:0]   w_v_idx_left;
  logic [VI_W-1:0]   w_v_idx_right;
  logic              w_blocked;
  logic [3:0]        w_nx;
  logic [3:0]        w_ny;
  state_t            w_state_nxt;
  logic [3:0]        w_pos_x_nxt;
  logic [3:0]        w_pos_y_nxt;
  logic [15:0]       w_moves_nxt;
  logic              w_bump_nxt;
  logic              w_win_nxt;

  // Fixed-priority direction decode: up > down > left > right
  always_comb begin
    w_dir = DIR_NONE;
    if (btn_up) begin
      w_dir = DIR_UP;
    end else if (btn_down) begin
      w_dir = DIR_DOWN;
    end else if (btn_left) begin
      w_dir = DIR_LEFT;
    end else if (btn_right) begin
      w_dir = DIR_RIGHT;
    end else begin
      w_dir = DIR_NONE;
    end
  end

  // Move request generation: fresh press, or auto-repeat once the hold counter expires
  always_comb begin
    w_req      = 1'b0;
    w_hold_nxt = r_hold_cnt;
    if (w_dir != DIR_NONE && w_dir != r_prev_dir) begin
      w_req      = 1'b1;
      w_hold_nxt = '0;
    end else if (w_dir != DIR_NONE && r_hold_cnt == LP_HOLD_LAST) begin
      w_req      = 1'b1;
      w_hold_nxt = LP_HOLD_RELOAD;
    end else if (w_dir != DIR_NONE) begin
      w_hold_nxt = r_hold_cnt + 1'b1;
    end else begin
      w_hold_nxt = '0;
    end
  end

  // Wall bit indices around the current cell (always in range for a legal position)
  always_comb begin
    w_h_idx_up    = HI_W'(int'(r_pos_y) * COLS + int'(r_pos_x));
    w_h_idx_down  = HI_W'((int'(r_pos_y) + 1) * COLS + int'(r_pos_x));
    w_v_idx_left  = VI_W'(int'(r_pos_y) * (COLS + 1) + int'(r_pos_x));
    w_v_idx_right = VI_W'(int'(r_pos_y) * (COLS + 1) + int'(r_pos_x) + 1);
  end

  // Candidate position and blocked test for the active direction (walls used live)
  always_comb begin
    w_blocked = 1'b1;
    w_nx      = r_pos_x;
    w_ny      = r_pos_y;
    case (w_dir)
      DIR_UP: begin
        w_blocked = (r_pos_y == 4'd0) || h_walls[w_h_idx_up];
        w_ny      = r_pos_y - 4'd1;
      end
      DIR_DOWN: begin
        w_blocked = (r_pos_y == LP_LAST_Y) || h_walls[w_h_idx_down];
        w_ny      = r_pos_y + 4'd1;
      end
      DIR_LEFT: begin
        w_blocked = (r_pos_x == 4'd0) || v_walls[w_v_idx_left];
        w_nx      = r_pos_x - 4'd1;
      end
      DIR_RIGHT: begin
        w_blocked = (r_pos_x == LP_LAST_X) || v_walls[w_v_idx_right];
        w_nx      = r_pos_x + 4'd1;
      end
      default: begin
        w_blocked = 1'b1;
      end
    endcase
  end

  // Game FSM next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_pos_x_nxt = r_pos_x;
    w_pos_y_nxt = r_pos_y;
    w_moves_nxt = r_moves;
    w_bump_nxt  = 1'b0;
    w_win_nxt   = r_win;
    case (r_state)
      ST_WAIT: begin
        w_pos_x_nxt = 4'd0;
        w_pos_y_nxt = 4'd0;
        w_moves_nxt = 16'd0;
        w_win_nxt   = 1'b0;
        if (maze_ready) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_PLAY: begin
        if (!maze_ready) begin
          w_state_nxt = ST_WAIT;
          w_pos_x_nxt = 4'd0;
          w_pos_y_nxt = 4'd0;
          w_moves_nxt = 16'd0;
          w_win_nxt   = 1'b0;
        end else if (w_req && w_blocked) begin
          w_bump_nxt = 1'b1;
        end else if (w_req) begin
          w_pos_x_nxt = w_nx;
          w_pos_y_nxt = w_ny;
          if (r_moves != 16'hFFFF) begin
            w_moves_nxt = r_moves + 16'd1;
          end else begin
            w_moves_nxt = r_moves;
          end
          if (w_nx == LP_GOAL_X && w_ny == LP_GOAL_Y) begin
            w_state_nxt = ST_WIN;
            w_win_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_PLAY;
          end
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_WIN: begin
        if (!maze_ready) begin
          w_state_nxt = ST_WAIT;
          w_pos_x_nxt = 4'd0;
          w_pos_y_nxt = 4'd0;
          w_moves_nxt = 16'd0;
          w_win_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_WIN;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT;
        w_pos_x_nxt = 4'd0;
        w_pos_y_nxt = 4'd0;
        w_moves_nxt = 16'd0;
        w_win_nxt   = 1'b0;
      end
    endcase
  end

  // State, hold tracking and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_WAIT;
      r_prev_dir <= DIR_NONE;
      r_hold_cnt <= '0;
      r_pos_x    <= 4'd0;
      r_pos_y    <= 4'd0;
      r_moves    <= 16'd0;
      r_bump     <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_dir <= w_dir;
      r_hold_cnt <= w_hold_nxt;
      r_pos_x    <= w_pos_x_nxt;
      r_pos_y    <= w_pos_y_nxt;
      r_moves    <= w_moves_nxt;
      r_bump     <= w_bump_nxt;
      r_win      <= w_win_nxt;
    end
  end

  assign pos_x = r_pos_x;
  assign pos_y = r_pos_y;
  assign moves = r_moves;
  assign bump  = r_bump;
  assign win   = r_win;

endmodule

// File: doc/maze_player_ctrl.md
Name: maze_player_ctrl

Overview:
- Consumes the wall map from maze_generator (h_walls, v_walls, busy inverted to maze_ready) and moves a player token cell by cell from player buttons.
- Checks walls and bounds, counts moves, detects the goal cell and generates hold-to-repeat motion.
- Sits directly downstream of maze_generator.
- Outputs feed the display and score logic.

Parameters:
- COLS, 10, maze width in cells.
- ROWS, 15, maze height in cells.
- GOAL_X, 9, goal column.
- GOAL_Y, 14, goal row.
- REPEAT_DELAY, 8, cycles a direction must be held before the first auto-repeat; must be ≥ 2.
- REPEAT_PERIOD, 4, cycles between subsequent auto-repeats; must be in 1..REPEAT_DELAY.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- maze_ready  in  1  high while the wall map is valid (maze_generator busy low).
- h_walls  in  COLS*(ROWS+1)  bit r*COLS+c set = wall on top edge of cell (c,r); row index r=ROWS is the bottom edge.
- v_walls  in  ROWS*(COLS+1)  bit r*(COLS+1)+c set = wall on left edge of cell (c,r); column index c=COLS is the right edge.
- btn_up, btn_down, btn_left, btn_right  in  1 each  level buttons, synchronous to clk.
- pos_x  out  4  player column.
- pos_y  out  4  player row.
- moves  out  16  count of successful moves.
- bump  out  1  one-cycle pulse on a blocked move attempt.
- win  out  1  high while the player is on the goal cell.

Behaviour:
- Reset values:
  - state=WAIT, pos_x=0, pos_y=0, moves=0, bump=0, win=0.
  - hold_cnt=0, prev_dir=NONE.
- Active direction dir, fixed priority up > down > left > right; NONE if no button is pressed.
- dir and prev_dir (registered dir) are computed every cycle in every state.
- Move request this cycle, when any of:
  - dir≠NONE and dir≠prev_dir: new press or direction change. hold_cnt<=0.
  - dir==prev_dir≠NONE and hold_cnt==REPEAT_DELAY-1: repeat. hold_cnt<=REPEAT_DELAY-REPEAT_PERIOD.
- hold_cnt when no request:
  - dir==prev_dir≠NONE: hold_cnt increments.
  - dir==NONE: hold_cnt<=0.
- Result: with a button held from cycle 0, moves occur at cycles 0, REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, and so on.
- Blocked test for cell (x,y):
  - up: y==0 or h_walls[y*COLS+x].
  - down: y==ROWS-1 or h_walls[(y+1)*COLS+x].
  - left: x==0 or v_walls[y*(COLS+1)+x].
  - right: x==COLS-1 or v_walls[y*(COLS+1)+x+1].
- Latency: request at cycle t updates pos and moves, or pulses bump, on the clock edge ending cycle t.
  - Outputs are visible in cycle t+1.
  - bump high for exactly that one cycle.
- State machine:
  - WAIT: pos=(0,0), moves=0, requests ignored. maze_ready=1 → PLAY next cycle.
  - PLAY: requests processed as above.
    - Successful move onto (GOAL_X,GOAL_Y) → WIN in the same edge; win=1 from t+1.
  - WIN: requests ignored, bump stays 0, pos and moves frozen.
- maze_ready=0 in PLAY or WIN → WAIT next edge.
  - pos, moves and win are cleared on that same edge.
  - A request in that cycle is ignored.
- moves saturates at 16'hFFFF; further successful moves still update pos.
- Walls are used live, not latched; they are only meaningful while maze_ready=1.
- rst=1 in any cycle, including mid-repeat, restores all reset values on that edge and overrides all other events.

Test Plan:
- Open interior maze (outer walls only), maze_ready=1, pulse btn_right 1 cycle → pos=(1,0) next cycle, moves=1, bump=0.
- Same maze, at (0,0) pulse btn_up → pos stays (0,0), bump=1 for one cycle, moves unchanged.
- Set v_walls[1] (wall between (0,0) and (1,0)), pulse btn_right → bump=1, pos=(0,0).
- Hold btn_down 20 cycles from (0,0), defaults → moves at cycles 0, 8, 12, 16; pos_y=4, moves=4.
- Press btn_up and btn_right together at (0,5) → up wins, pos=(0,4).
- Walk to (9,14) → win=1. Further presses leave pos and moves unchanged.
  - Drop maze_ready 1 cycle → pos=(0,0), moves=0, win=0.
  - rst asserted mid-hold → all outputs at reset values next cycle.
